// File: rtl/sd_cmd_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sd_cmd_defs (package)
// Brief   : Shared constants and state encoding for the SD CMD-line responder.
// Revision: 1.0
// ============================================================================
package sd_cmd_defs;

    localparam int unsigned CMD_FRAME_LEN = 48;
    localparam int unsigned CRC_LEN       = 7;
    localparam logic [6:0]  CRC7_POLY     = 7'h09;

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_RECV  = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHECK = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] ST_SEND  = 3'd4;

    // Bit positions within a frame, counted from the start bit (0).
    localparam logic [5:0] FRAME_LAST_BIT  = 6'(CMD_FRAME_LEN - 1);
    localparam logic [5:0] CRC_FIELD_START = 6'(CMD_FRAME_LEN - CRC_LEN - 1);

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// ============================================================================
// Module  : sd_crc7
// Brief   : Serial CRC7 (x^7+x^3+1) generator, synchronous clear over enable.
// Revision: 1.0
// ============================================================================
module sd_crc7
    import sd_cmd_defs::*;
(
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               bit_in,
    output logic [CRC_LEN-1:0] crc
);

    logic w_feedback;

    assign w_feedback = bit_in ^ crc[CRC_LEN-1];

    always_ff @(posedge sd_clock) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC_LEN-2:0], 1'b0} ^ (w_feedback ? CRC7_POLY : 7'd0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module  : sd_cmd_responder
// Brief   : Card-side CMD endpoint: decodes host frames, answers with R1 frames.
// Revision: 1.0
// ============================================================================
module sd_cmd_responder
    import sd_cmd_defs::*;
#(
    parameter int NCR = 2
)
(
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        cmd_in,
    input  logic        resp_enable,
    input  logic [31:0] resp_arg,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        cmd_valid,
    output logic        crc_error,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        busy
);

    localparam logic [5:0] c_ncr_last = 6'(NCR - 1);
    localparam logic [5:0] c_crc_end  = 6'(CMD_FRAME_LEN - 2);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic [5:0]         r_bit_cnt;
    logic [5:0]         r_ncr_cnt;
    logic [47:0]        r_rx_sr;
    logic [47:0]        r_tx_sr;
    logic [5:0]         r_cmd_index;
    logic [31:0]        r_cmd_arg;
    logic [6:0]         w_rx_crc;
    logic [6:0]         w_tx_crc;
    logic [2:0]         w_crc_sel;
    logic               w_frame_ok;
    logic               w_respond;
    logic               w_rx_clear;
    logic               w_rx_en;
    logic               w_tx_clear;
    logic               w_tx_en;
    logic               w_tx_bit;

    // ------------------------------------------------------------------------
    // CRC engines. The receive CRC must restart from zero on an aborted frame
    // because a new start bit may follow on the very next cycle.
    // ------------------------------------------------------------------------
    assign w_rx_en    = ((r_state == ST_IDLE) && !cmd_in) ||
                        ((r_state == ST_RECV) && (r_bit_cnt < CRC_FIELD_START));
    assign w_rx_clear = (r_state == ST_RECV) ? ((r_bit_cnt == 6'd1) && !cmd_in)
                                             : !((r_state == ST_IDLE) && !cmd_in);

    assign w_tx_clear = (r_state != ST_SEND);
    assign w_tx_en    = (r_state == ST_SEND) && (r_bit_cnt < CRC_FIELD_START);

    sd_crc7 u_rx_crc (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (w_rx_clear),
        .enable   (w_rx_en),
        .bit_in   (cmd_in),
        .crc      (w_rx_crc)
    );

    sd_crc7 u_tx_crc (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (w_tx_clear),
        .enable   (w_tx_en),
        .bit_in   (r_tx_sr[47]),
        .crc      (w_tx_crc)
    );

    // The CRC field of the transmit register is loaded with zeros; the running
    // CRC is frozen after bit 39 and muxed onto the line bit by bit.
    assign w_crc_sel = 3'(c_crc_end - r_bit_cnt);
    assign w_tx_bit  = ((r_bit_cnt >= CRC_FIELD_START) && (r_bit_cnt < FRAME_LAST_BIT))
                       ? w_tx_crc[w_crc_sel] : r_tx_sr[47];

    assign w_frame_ok = !r_rx_sr[47] && r_rx_sr[46] && r_rx_sr[0] &&
                        (r_rx_sr[7:1] == w_rx_crc);
    assign w_respond  = resp_enable && (r_rx_sr[45:40] != 6'd0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!cmd_in) w_state_next = ST_RECV;
            end
            ST_RECV: begin
                if ((r_bit_cnt == 6'd1) && !cmd_in) w_state_next = ST_IDLE;
                else if (r_bit_cnt == FRAME_LAST_BIT) w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_state_next = (w_frame_ok && w_respond) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                if (r_ncr_cnt == c_ncr_last) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (r_bit_cnt == FRAME_LAST_BIT) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: shift registers, counters, decoded command
    // ------------------------------------------------------------------------
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_bit_cnt   <= 6'd0;
            r_ncr_cnt   <= 6'd0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '1;
            r_cmd_index <= 6'd0;
            r_cmd_arg   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= 6'd1;
                    r_rx_sr   <= {r_rx_sr[46:0], cmd_in};
                end
                ST_RECV: begin
                    r_rx_sr   <= {r_rx_sr[46:0], cmd_in};
                    r_bit_cnt <= (r_bit_cnt == FRAME_LAST_BIT) ? 6'd0 : r_bit_cnt + 6'd1;
                end
                ST_CHECK: begin
                    r_ncr_cnt <= 6'd0;
                    if (w_frame_ok) begin
                        r_cmd_index <= r_rx_sr[45:40];
                        r_cmd_arg   <= r_rx_sr[39:8];
                    end
                end
                ST_WAIT: begin
                    if (r_ncr_cnt == c_ncr_last) begin
                        r_tx_sr   <= {2'b00, r_cmd_index, resp_arg, 7'd0, 1'b1};
                        r_bit_cnt <= 6'd0;
                    end else begin
                        r_ncr_cnt <= r_ncr_cnt + 6'd1;
                    end
                end
                ST_SEND: begin
                    r_tx_sr   <= {r_tx_sr[46:0], 1'b1};
                    r_bit_cnt <= (r_bit_cnt == FRAME_LAST_BIT) ? 6'd0 : r_bit_cnt + 6'd1;
                end
                default: begin
                    r_bit_cnt <= 6'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. A good command is visible on cmd_index/cmd_arg during the
    // same cycle that cmd_valid pulses.
    // ------------------------------------------------------------------------
    always_comb begin
        cmd_oe    = 1'b0;
        cmd_out   = 1'b1;
        cmd_valid = 1'b0;
        crc_error = 1'b0;
        busy      = (r_state != ST_IDLE);
        cmd_index = r_cmd_index;
        cmd_arg   = r_cmd_arg;
        case (r_state)
            ST_CHECK: begin
                cmd_valid = w_frame_ok;
                crc_error = !w_frame_ok;
                if (w_frame_ok) begin
                    cmd_index = r_rx_sr[45:40];
                    cmd_arg   = r_rx_sr[39:8];
                end
            end
            ST_SEND: begin
                cmd_oe  = 1'b1;
                cmd_out = w_tx_bit;
            end
            default: begin
                cmd_oe = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_cmd_responder
// Brief   : Self-checking bench; per-edge expectations from a timeline model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sd_cmd_responder;

    localparam int NCR   = 2;
    localparam int DEPTH = 2048;

    localparam logic [47:0] F_CMD0    = 48'h40_00000000_95;
    localparam logic [47:0] F_CMD8    = 48'h48_000001AA_87;
    localparam logic [47:0] F_CMD17   = 48'h51_00000000_55;
    localparam logic [47:0] F_CMD17_B = 48'h51_00000000_57;

    logic        sd_clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_in = 1'b1;
    logic        resp_enable = 1'b1;
    logic [31:0] resp_arg = 32'd0;
    logic        cmd_out, cmd_oe, cmd_valid, crc_error, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected output value present just before edge number [i].
    bit          exp_oe    [DEPTH];
    bit          exp_out   [DEPTH];
    bit          exp_valid [DEPTH];
    bit          exp_err   [DEPTH];
    bit          exp_busy  [DEPTH];
    logic [5:0]  exp_idx   [DEPTH];
    logic [31:0] exp_arg   [DEPTH];

    sd_cmd_responder #(.NCR(NCR)) dut (
        .sd_clock    (sd_clock),
        .reset       (reset),
        .cmd_in      (cmd_in),
        .resp_enable (resp_enable),
        .resp_arg    (resp_arg),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .cmd_valid   (cmd_valid),
        .crc_error   (crc_error),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .busy        (busy)
    );

    always #5 sd_clock = ~sd_clock;
    always @(posedge sd_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s before edge %0d: got %h, expected %h", name, cyc + 1, act, exp);
        end
    endtask

    // CRC7 as polynomial long division of data*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    // Schedule the expected outputs of a frame whose start bit is sampled at edge e0.
    task automatic model_cmd(input int e0, input logic [47:0] f, input bit ren,
                             input logic [31:0] rarg);
        logic [47:0] rf;
        logic [5:0]  idx;
        bit          good;
        if (!f[46]) begin
            exp_busy[e0 + 1] = 1'b1;
            return;
        end
        for (int i = e0 + 1; i <= e0 + 48; i++) exp_busy[i] = 1'b1;
        good = (crc7_ref(f[47:8]) == f[7:1]) && f[0];
        if (!good) begin
            exp_err[e0 + 48] = 1'b1;
            return;
        end
        idx = f[45:40];
        exp_valid[e0 + 48] = 1'b1;
        for (int i = e0 + 48; i < DEPTH; i++) begin
            exp_idx[i] = idx;
            exp_arg[i] = f[39:8];
        end
        if (ren && idx != 6'd0) begin
            rf = {2'b00, idx, rarg, crc7_ref({2'b00, idx, rarg}), 1'b1};
            for (int i = e0 + 49; i <= e0 + 96 + NCR; i++) exp_busy[i] = 1'b1;
            for (int i = 0; i < 48; i++) begin
                exp_oe[e0 + 49 + NCR + i]  = 1'b1;
                exp_out[e0 + 49 + NCR + i] = rf[47 - i];
            end
        end
    endtask

    // Reset sampled at edge e: everything idle from the following edge on.
    task automatic model_reset(input int e);
        for (int i = e + 1; i < DEPTH; i++) begin
            exp_idx[i] = 6'd0;
            exp_arg[i] = 32'd0;
        end
        for (int i = e + 1; i <= e + 60; i++) begin
            exp_oe[i]   = 1'b0;
            exp_out[i]  = 1'b1;
            exp_busy[i] = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            cmd_in = f[47 - i];
            @(posedge sd_clock);
            #1;
        end
        cmd_in = 1'b1;
    endtask

    task automatic idle(input int n);
        cmd_in = 1'b1;
        repeat (n) begin
            @(posedge sd_clock);
            #1;
        end
    endtask

    // Park on the negedge just before edge x.
    task automatic probe_at(input int x);
        while (cyc < x - 1) @(posedge sd_clock);
        @(negedge sd_clock);
    endtask

    always @(negedge sd_clock) begin
        if (cyc + 1 < DEPTH) begin
            check("cmd_oe",    {31'd0, cmd_oe},    {31'd0, exp_oe[cyc + 1]});
            check("cmd_out",   {31'd0, cmd_out},   {31'd0, exp_out[cyc + 1]});
            check("cmd_valid", {31'd0, cmd_valid}, {31'd0, exp_valid[cyc + 1]});
            check("crc_error", {31'd0, crc_error}, {31'd0, exp_err[cyc + 1]});
            check("busy",      {31'd0, busy},      {31'd0, exp_busy[cyc + 1]});
            check("cmd_index", {26'd0, cmd_index}, {26'd0, exp_idx[cyc + 1]});
            check("cmd_arg",   cmd_arg,            exp_arg[cyc + 1]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_oe[i] = 1'b0;  exp_out[i] = 1'b1; exp_valid[i] = 1'b0;
            exp_err[i] = 1'b0; exp_busy[i] = 1'b0;
            exp_idx[i] = 6'd0; exp_arg[i] = 32'd0;
        end
        repeat (3) @(posedge sd_clock);
        #1;
        reset = 1'b0;

        check("crc7_cmd0",  {25'd0, crc7_ref(F_CMD0[47:8])},  32'h4A);
        check("crc7_cmd8",  {25'd0, crc7_ref(F_CMD8[47:8])},  32'h43);
        check("crc7_cmd17", {25'd0, crc7_ref(F_CMD17[47:8])}, 32'h2A);
        idle(4);

        // CMD0: decoded, never answered.
        e0 = cyc + 1;
        model_cmd(e0, F_CMD0, 1'b1, resp_arg);
        send_frame(F_CMD0, 48);
        probe_at(e0 + 48);
        check("cmd0_valid", {31'd0, cmd_valid}, 32'd1);
        @(posedge sd_clock); #1;
        idle(5);

        // CMD8: answered after NCR; resp_enable dropped during WAIT is ignored.
        resp_arg = 32'h0000_01AA;
        e0 = cyc + 1;
        model_cmd(e0, F_CMD8, 1'b1, resp_arg);
        send_frame(F_CMD8, 48);
        idle(2);
        resp_enable = 1'b0;
        probe_at(e0 + 51);
        check("cmd8_resp_start_oe",  {31'd0, cmd_oe},  32'd1);
        check("cmd8_resp_start_bit", {31'd0, cmd_out}, 32'd0);
        probe_at(e0 + 99);
        check("cmd8_oe_released", {31'd0, cmd_oe}, 32'd0);
        @(posedge sd_clock); #1;
        resp_enable = 1'b1;
        idle(3);
        check("cmd8_index_held", {26'd0, cmd_index}, 32'd8);
        check("cmd8_arg_held",   cmd_arg,            32'h0000_01AA);

        // CMD17 with corrupted CRC byte.
        e0 = cyc + 1;
        model_cmd(e0, F_CMD17_B, 1'b1, resp_arg);
        send_frame(F_CMD17_B, 48);
        probe_at(e0 + 48);
        check("bad_crc_error", {31'd0, crc_error}, 32'd1);
        check("bad_keep_index", {26'd0, cmd_index}, 32'd8);
        @(posedge sd_clock); #1;
        idle(3);

        // Start bit plus transmission bit 0, then a good CMD17 straight away.
        resp_arg = 32'h0000_0900;
        e0 = cyc + 1;
        model_cmd(e0, 48'h0, 1'b1, resp_arg);
        send_frame(48'h0, 2);
        e1 = cyc + 1;
        model_cmd(e1, F_CMD17, 1'b1, resp_arg);
        send_frame(F_CMD17, 48);
        idle(60);
        check("cmd17_index", {26'd0, cmd_index}, 32'd17);
        idle(3);

        // Reset in the middle of a CMD8 response.
        resp_arg = 32'h0000_01AA;
        e0 = cyc + 1;
        model_cmd(e0, F_CMD8, 1'b1, resp_arg);
        send_frame(F_CMD8, 48);
        while (cyc < e0 + 69) begin
            @(posedge sd_clock);
            #1;
        end
        reset = 1'b1;
        model_reset(e0 + 70);
        @(posedge sd_clock); #1;
        reset = 1'b0;
        probe_at(e0 + 71);
        check("rst_oe",   {31'd0, cmd_oe},  32'd0);
        check("rst_out",  {31'd0, cmd_out}, 32'd1);
        check("rst_busy", {31'd0, busy},    32'd0);
        @(posedge sd_clock); #1;
        idle(3);
        e0 = cyc + 1;
        model_cmd(e0, F_CMD8, 1'b1, resp_arg);
        send_frame(F_CMD8, 48);
        idle(60);

        // resp_enable=0 CMD8, then a second CMD8 starting one cycle after CHECK.
        resp_enable = 1'b0;
        e0 = cyc + 1;
        model_cmd(e0, F_CMD8, 1'b0, resp_arg);
        send_frame(F_CMD8, 48);
        idle(1);
        resp_enable = 1'b1;
        e1 = cyc + 1;
        model_cmd(e1, F_CMD8, 1'b1, resp_arg);
        send_frame(F_CMD8, 48);
        idle(60);
        check("b2b_start_edge", e1, e0 + 49);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_cmd_responder.md
# sd_cmd_responder

Card-side endpoint of the SD CMD line. It receives 48-bit host command frames serially, checks the framing and CRC7, and presents the command index and argument to card logic. It then answers with a 48-bit R1-format response frame after a programmable NCR gap. It pairs with the host's cmd_phys/cmd_controller path: it is the responder for the host's initiator, used in card models and loopback benches.

## Interface
- NCR, default 2: idle cycles between the end bit of a command and the start bit of the response; legal range is 2..63.
- sd_clock  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_in  in  1  serial CMD line from the host; idles high.
- resp_enable  in  1  when 1, a valid command other than CMD0 gets a response.
- resp_arg  in  32  response status word; sampled on the last WAIT cycle.
- cmd_out  out  1  serial response bit; reset value 1.
- cmd_oe  out  1  CMD line drive enable; reset value 0.
- cmd_valid  out  1  one-cycle pulse on a good command; reset value 0.
- crc_error  out  1  one-cycle pulse on a bad CRC or bad end bit; reset value 0.
- cmd_index  out  6  index of the last good command; reset value 0.
- cmd_arg  out  32  argument of the last good command; reset value 0.
- busy  out  1  high in any state other than IDLE; reset value 0.

## Operation
- Host frame, MSB first: start bit 0, transmission bit 1, index[5:0], arg[31:0], CRC7[6:0], end bit 1.
- CRC7 polynomial is x^7+x^3+1 with initial value 0. It is computed over the first 40 bits.
- States: IDLE, RECV, CHECK, WAIT, SEND.
- IDLE: cmd_in=0 moves to RECV, and that start bit counts as bit 0.
- RECV: shift cmd_in into the 48-bit frame register.
  - If bit 1 (the transmission bit) is 0, return to IDLE silently, with no flags. This covers card-to-card traffic and glitches.
  - After bit 47 is sampled, go to CHECK.
- CHECK, one cycle:
  - Good frame (CRC match and end bit 1): pulse cmd_valid and load cmd_index/cmd_arg in the same cycle.
    - Go to WAIT if resp_enable=1 and index≠0.
    - Otherwise go to IDLE.
  - Bad frame: pulse crc_error, leave cmd_index/cmd_arg unchanged, go to IDLE.
- WAIT: count NCR cycles with cmd_oe=0.
  - On the last WAIT cycle, latch resp_arg and the echoed index into the response shift register.
  - Response frame: start bit 0, transmission bit 0, index, resp_arg, CRC7, end bit 1.
- SEND: 48 cycles with cmd_oe=1 and cmd_out = the current MSB, then return to IDLE with cmd_oe=0 and cmd_out=1.
- cmd_in is ignored during CHECK, WAIT and SEND. The responder never decodes its own response.

## Timing
- The start bit is sampled at edge E0, and the end bit at edge E0+47.
- CHECK is the state during cycle E0+48, so cmd_valid and crc_error are high for exactly that cycle.
- WAIT covers cycles E0+49 .. E0+48+NCR.
- The response start bit is driven during cycle E0+49+NCR. The end bit is driven in cycle E0+96+NCR.
- cmd_oe drops to 0 at edge E0+97+NCR.
- Back-to-back commands: a start bit is accepted on the first cycle back in IDLE. No extra turnaround cycle is required.
- Reset (synchronous) during any state: on the next edge the block is in IDLE with every output at its reset value.
  - A response in progress is truncated and cmd_oe drops immediately.
  - A partial frame is discarded without flags.
- resp_enable is sampled in CHECK only. Changes during WAIT or SEND have no effect.
- Counter widths: the bit counter is 6 bits, wrapping 0..47. The NCR counter is 6 bits. Neither counter is allowed to wrap past its terminal value.

## Structure
- Shared package/header, sd_cmd_defs:
  - state encoding (IDLE=0, RECV=1, CHECK=2, WAIT=3, SEND=4)
  - CMD_FRAME_LEN=48, CRC_LEN=7, CRC7_POLY=7'h09
- Sub-module sd_crc7 is a serial CRC7 generator with ports sd_clock, reset, clear, enable, bit_in, crc[6:0].
  - Two instances: one for receive, one for the response.
  - clear is synchronous and has priority over enable.
- The responder holds the FSM, the 48-bit receive shift register, the 48-bit transmit shift register, and the two counters.

## Test plan
- Send CMD0 with arg 0 (frame 0x40_00000000_95) -> cmd_valid pulses at E0+48 with cmd_index=0, cmd_arg=0; no response (cmd_oe stays 0); busy is back to 0 at E0+49.
- Send CMD8 with arg 0x1AA (0x48_000001AA_87), resp_arg=0x000001AA, NCR=2 -> cmd_valid at E0+48; response start bit at E0+51; response frame 0x08_000001AA_xx with a correct CRC7 and end bit 1; cmd_oe low at E0+99.
- Send CMD17 with arg 0 (0x51_00000000_55) with the CRC byte corrupted to 0x57 -> crc_error pulses at E0+48, cmd_valid stays 0, cmd_index/cmd_arg keep their previous values, no response.
- Send a start bit followed by a transmission bit of 0 -> silent return to IDLE with no flags; a valid CMD17 sent immediately afterwards is decoded correctly.
- Assert reset at E0+70 during SEND of the CMD8 response -> next edge shows cmd_oe=0, cmd_out=1, busy=0; a following CMD8 is answered normally.
- Send CMD8 with resp_enable=0, then CMD8 immediately after the first end bit -> first gets cmd_valid with no response; second is decoded with its start bit accepted at E0+49.
